// File: rtl/doc_safety_crosscheck_pkg.sv
// Shared types and helpers for the redundant safety-channel cross-check.
// Payload layout: {overspeed, speed_rpm[24:0] signed, seq[5:0]}.
package doc_safety_crosscheck_pkg;

  localparam int unsigned C_PAYLOAD_W = 32;
  localparam int unsigned C_SPEED_W   = 25;
  localparam int unsigned C_SEQ_W     = 6;
  localparam int unsigned C_FAULT_W   = 4;

  typedef struct packed {
    logic                 overspeed;
    logic [C_SPEED_W-1:0] speed_rpm;
    logic [C_SEQ_W-1:0]   seq;
  } t_safety_payload;

  // Field order puts mismatch at bit0 and overspeed at bit3.
  typedef struct packed {
    logic overspeed;
    logic timeout;
    logic seq_err;
    logic mismatch;
  } t_fault_code;

  typedef enum logic [2:0] {
    XCHK_IDLE  = 3'd0,
    XCHK_WAIT0 = 3'd1,
    XCHK_WAIT1 = 3'd2,
    XCHK_CHECK = 3'd3,
    XCHK_FAULT = 3'd4
  } t_xchk_state;

  function automatic t_safety_payload fcn_logic_to_payload(input logic [C_PAYLOAD_W-1:0] v);
    return t_safety_payload'(v);
  endfunction

  function automatic logic [C_PAYLOAD_W-1:0] fcn_payload_to_logic(input t_safety_payload p);
    return C_PAYLOAD_W'(p);
  endfunction

  function automatic logic [C_SEQ_W-1:0] fcn_seq_next(input logic [C_SEQ_W-1:0] s);
    return s + C_SEQ_W'(1);
  endfunction

  // One extra bit keeps the difference of opposite-extreme speeds from wrapping.
  function automatic logic fcn_speed_within_margin(input logic [C_SPEED_W-1:0] s0,
                                                   input logic [C_SPEED_W-1:0] s1,
                                                   input logic [C_SPEED_W-1:0] margin);
    logic signed [C_SPEED_W:0] a;
    logic signed [C_SPEED_W:0] b;
    logic signed [C_SPEED_W:0] d;
    logic        [C_SPEED_W:0] mag;
    a   = {s0[C_SPEED_W-1], s0};
    b   = {s1[C_SPEED_W-1], s1};
    d   = a - b;
    mag = d[C_SPEED_W] ? $unsigned(-d) : $unsigned(d);
    return mag <= {1'b0, margin};
  endfunction

endpackage

// File: rtl/doc_safety_xchk_timer.sv
// Shared timeout counter: counts while enabled, clears on request, and flags
// expiry against either the pair or the frame limit.
module doc_safety_xchk_timer #(
  parameter int unsigned C_PAIR_TIMEOUT  = 64,
  parameter int unsigned C_FRAME_TIMEOUT = 100000,
  parameter int unsigned C_CNT_WIDTH     = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel_pair,
  output logic expired_c
);

  localparam logic [C_CNT_WIDTH-1:0] C_PAIR_LAST  = C_CNT_WIDTH'(C_PAIR_TIMEOUT - 1);
  localparam logic [C_CNT_WIDTH-1:0] C_FRAME_LAST = C_CNT_WIDTH'(C_FRAME_TIMEOUT - 1);
  localparam logic [C_CNT_WIDTH-1:0] C_ONE        = C_CNT_WIDTH'(1);

  logic [C_CNT_WIDTH-1:0] count;

  // Expiry is seen during the limit-th cycle so the FSM leaves on that edge.
  assign expired_c = count >= (sel_pair ? C_PAIR_LAST : C_FRAME_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired_c) begin
      count <= count + C_ONE;
    end
  end

endmodule

// File: rtl/doc_safety_crosscheck.sv
// Pairs the two safety-channel payloads, cross-checks them and latches a
// safe-stop request. Optional err_count output under DOC_SAFETY_XCHK_STATS_EN.
module doc_safety_crosscheck
  import doc_safety_crosscheck_pkg::*;
#(
  parameter int unsigned C_PAIR_TIMEOUT  = 64,
  parameter int unsigned C_FRAME_TIMEOUT = 100000,
  parameter int unsigned C_CNT_WIDTH     = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ch0_payload,
  input  logic        ch0_valid,
  input  logic [31:0] ch1_payload,
  input  logic        ch1_valid,
  input  logic [24:0] speed_margin,
  input  logic        fault_clr,
  output logic        pair_valid,
  output logic [24:0] pair_speed,
  output logic        safe_stop,
  output logic [3:0]  fault_code
`ifdef DOC_SAFETY_XCHK_STATS_EN
  ,
  output logic [15:0] err_count
`endif
);

  t_xchk_state            state, state_nxt, start_state;
  logic [C_PAYLOAD_W-1:0] cap0, cap0_nxt, cap1, cap1_nxt;
  logic [C_SEQ_W-1:0]     last_seq, last_seq_nxt;
  logic                   first_pair, first_pair_nxt;
  logic                   pair_valid_nxt;
  logic [C_SPEED_W-1:0]   pair_speed_nxt;
  logic [C_FAULT_W-1:0]   fault_code_nxt;
  logic                   tmr_clr, tmr_en, tmr_sel_pair, tmr_expired_c;
  t_safety_payload        p0, p1;
  t_fault_code            chk;

  doc_safety_xchk_timer #(
    .C_PAIR_TIMEOUT (C_PAIR_TIMEOUT),
    .C_FRAME_TIMEOUT(C_FRAME_TIMEOUT),
    .C_CNT_WIDTH    (C_CNT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .sel_pair (tmr_sel_pair),
    .expired_c(tmr_expired_c)
  );

  // Cross-channel checks on the captured pair.
  always_comb begin
    p0            = fcn_logic_to_payload(cap0);
    p1            = fcn_logic_to_payload(cap1);
    chk           = '0;
    chk.mismatch  = !fcn_speed_within_margin(p0.speed_rpm, p1.speed_rpm, speed_margin);
    chk.seq_err   = (p0.seq != p1.seq) || (!first_pair && (p0.seq != fcn_seq_next(last_seq)));
    chk.overspeed = p0.overspeed | p1.overspeed;
  end

  // Where a new frame goes depending on which strobes opened it.
  always_comb begin
    start_state = XCHK_WAIT0;
    if (ch0_valid && ch1_valid) start_state = XCHK_CHECK;
    else if (ch0_valid)         start_state = XCHK_WAIT1;
  end

  always_comb begin
    state_nxt      = state;
    cap0_nxt       = cap0;
    cap1_nxt       = cap1;
    last_seq_nxt   = last_seq;
    first_pair_nxt = first_pair;
    pair_valid_nxt = 1'b0;
    pair_speed_nxt = pair_speed;
    fault_code_nxt = fault_code;

    case (state)
      XCHK_IDLE: begin
        if (ch0_valid) cap0_nxt = ch0_payload;
        if (ch1_valid) cap1_nxt = ch1_payload;
        if (ch0_valid || ch1_valid) begin
          state_nxt = start_state;
        end else if (tmr_expired_c) begin
          state_nxt      = XCHK_FAULT;
          fault_code_nxt = 4'b0100;
        end
      end
      XCHK_WAIT0: begin
        if (ch1_valid) begin
          state_nxt      = XCHK_FAULT;
          fault_code_nxt = 4'b0010;
        end else if (ch0_valid) begin
          cap0_nxt  = ch0_payload;
          state_nxt = XCHK_CHECK;
        end else if (tmr_expired_c) begin
          state_nxt      = XCHK_FAULT;
          fault_code_nxt = 4'b0100;
        end
      end
      XCHK_WAIT1: begin
        if (ch0_valid) begin
          state_nxt      = XCHK_FAULT;
          fault_code_nxt = 4'b0010;
        end else if (ch1_valid) begin
          cap1_nxt  = ch1_payload;
          state_nxt = XCHK_CHECK;
        end else if (tmr_expired_c) begin
          state_nxt      = XCHK_FAULT;
          fault_code_nxt = 4'b0100;
        end
      end
      XCHK_CHECK: begin
        if (chk != '0) begin
          state_nxt      = XCHK_FAULT;
          fault_code_nxt = chk;
        end else begin
          pair_valid_nxt = 1'b1;
          pair_speed_nxt = p0.speed_rpm;
          last_seq_nxt   = p0.seq;
          first_pair_nxt = 1'b0;
          state_nxt      = XCHK_IDLE;
          // Strobes landing here open the next frame.
          if (ch0_valid) cap0_nxt = ch0_payload;
          if (ch1_valid) cap1_nxt = ch1_payload;
          if (ch0_valid || ch1_valid) state_nxt = start_state;
        end
      end
      XCHK_FAULT: begin
        if (fault_clr) begin
          state_nxt      = XCHK_IDLE;
          fault_code_nxt = '0;
          first_pair_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = XCHK_IDLE;
      end
    endcase

    tmr_en       = 1'b1;
    tmr_sel_pair = (state == XCHK_WAIT0) || (state == XCHK_WAIT1);
    tmr_clr      = (state_nxt != state) || (state == XCHK_CHECK) || (state == XCHK_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= XCHK_IDLE;
      cap0       <= '0;
      cap1       <= '0;
      last_seq   <= '0;
      first_pair <= 1'b1;
      pair_valid <= 1'b0;
      pair_speed <= '0;
      safe_stop  <= 1'b0;
      fault_code <= '0;
    end else begin
      state      <= state_nxt;
      cap0       <= cap0_nxt;
      cap1       <= cap1_nxt;
      last_seq   <= last_seq_nxt;
      first_pair <= first_pair_nxt;
      pair_valid <= pair_valid_nxt;
      pair_speed <= pair_speed_nxt;
      safe_stop  <= (state_nxt == XCHK_FAULT);
      fault_code <= fault_code_nxt;
    end
  end

`ifdef DOC_SAFETY_XCHK_STATS_EN
  // Counts FAULT entries; survives fault_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if ((state_nxt == XCHK_FAULT) && (state != XCHK_FAULT) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_doc_safety_crosscheck.sv
// Directed bench for doc_safety_crosscheck: vector table of same-cycle pairs
// plus hand sequences for timeouts, split arrival, CHECK overlap and reset.
module tb_doc_safety_crosscheck;

  localparam int unsigned C_PAIR  = 64;
  localparam int unsigned C_FRAME = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ch0_payload, ch1_payload;
  logic        ch0_valid, ch1_valid;
  logic [24:0] speed_margin;
  logic        fault_clr;
  logic        pair_valid;
  logic [24:0] pair_speed;
  logic        safe_stop;
  logic [3:0]  fault_code;
`ifdef DOC_SAFETY_XCHK_STATS_EN
  logic [15:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_err  = 0;

  always #5 clk = ~clk;

  doc_safety_crosscheck #(
    .C_PAIR_TIMEOUT (C_PAIR),
    .C_FRAME_TIMEOUT(C_FRAME),
    .C_CNT_WIDTH    (17)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch0_payload (ch0_payload),
    .ch0_valid   (ch0_valid),
    .ch1_payload (ch1_payload),
    .ch1_valid   (ch1_valid),
    .speed_margin(speed_margin),
    .fault_clr   (fault_clr),
    .pair_valid  (pair_valid),
    .pair_speed  (pair_speed),
    .safe_stop   (safe_stop),
`ifdef DOC_SAFETY_XCHK_STATS_EN
    .err_count   (err_count),
`endif
    .fault_code  (fault_code)
  );

  typedef struct {
    bit          clr;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [24:0] margin;
    bit          pv;
    logic [24:0] speed;
    logic [3:0]  fc;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] mk(input bit ov, input int speed, input int seq);
    logic [24:0] s;
    logic [5:0]  q;
    s = 25'(speed);
    q = 6'(seq);
    return {ov, s, q};
  endfunction

  function automatic vec_t mkv(input bit clr, input logic [31:0] p0, input logic [31:0] p1,
                               input int margin, input bit pv, input int speed, input logic [3:0] fc);
    vec_t v;
    v.clr = clr; v.p0 = p0; v.p1 = p1; v.margin = 25'(margin);
    v.pv = pv; v.speed = 25'(speed); v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [31:0] p0, input bit v1, input logic [31:0] p1);
    ch0_valid = v0; ch0_payload = p0;
    ch1_valid = v1; ch1_payload = p1;
    step();
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
  endtask

  task automatic clear_fault(input string name);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk({name, "_clr_ss"}, 32'(safe_stop), 32'd0);
    chk({name, "_clr_fc"}, 32'(fault_code), 32'd0);
  endtask

  task automatic chk_err(input string name);
`ifdef DOC_SAFETY_XCHK_STATS_EN
    chk({name, "_errcnt"}, 32'(err_count), 32'(exp_err));
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  initial begin
    vecs[0]  = mkv(0, mk(0, 1000, 5),      mk(0, 1003, 5),     4,  1, 1000, 4'b0000);
    vecs[1]  = mkv(0, mk(0, 1000, 6),      mk(0, 1003, 6),     4,  1, 1000, 4'b0000);
    vecs[2]  = mkv(0, mk(0, 1000, 7),      mk(0, 1010, 7),     4,  0, 0,    4'b0001);
    vecs[3]  = mkv(1, mk(0, 500, 62),      mk(0, 500, 62),     0,  1, 500,  4'b0000);
    vecs[4]  = mkv(0, mk(0, -200, 63),     mk(0, -199, 63),    1,  1, -200, 4'b0000);
    vecs[5]  = mkv(0, mk(0, 0, 0),         mk(0, 0, 0),        0,  1, 0,    4'b0000);
    vecs[6]  = mkv(0, mk(0, 0, 2),         mk(0, 0, 2),        0,  0, 0,    4'b0010);
    vecs[7]  = mkv(1, mk(1, -16777216, 10), mk(0, 16777215, 10), 0, 0, 0,   4'b1001);
    vecs[8]  = mkv(1, mk(0, 7, 9),         mk(0, 7, 10),       0,  0, 0,    4'b0010);
    vecs[9]  = mkv(1, mk(0, 0, 20),        mk(1, 0, 20),       0,  0, 0,    4'b1000);
    vecs[10] = mkv(1, mk(0, -5, 30),       mk(0, 5, 30),       10, 1, -5,   4'b0000);
    vecs[11] = mkv(0, mk(0, -5, 31),       mk(0, 6, 31),       10, 0, 0,    4'b0001);
    vecs[12] = mkv(1, mk(0, 0, 0),         mk(0, 0, 0),        0,  1, 0,    4'b0000);
    vecs[13] = mkv(0, mk(0, 0, 3),         mk(0, 100, 3),      0,  0, 0,    4'b0011);

    rst = 1'b1; fault_clr = 1'b0; speed_margin = '0;
    ch0_valid = 1'b0; ch1_valid = 1'b0; ch0_payload = '0; ch1_payload = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_pv", 32'(pair_valid), 32'd0);
    chk("rst_speed", 32'(pair_speed), 32'd0);
    chk("rst_ss", 32'(safe_stop), 32'd0);
    chk("rst_fc", 32'(fault_code), 32'd0);
    chk_err("rst");

    // Same-cycle pairs: outputs appear two edges after the strobe edge.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].clr) clear_fault($sformatf("vec%0d", i));
      speed_margin = vecs[i].margin;
      drive(1'b1, vecs[i].p0, 1'b1, vecs[i].p1);
      chk($sformatf("vec%0d_early_pv", i), 32'(pair_valid), 32'd0);
      step();
      chk($sformatf("vec%0d_pv", i), 32'(pair_valid), 32'(vecs[i].pv));
      chk($sformatf("vec%0d_fc", i), 32'(fault_code), 32'(vecs[i].fc));
      chk($sformatf("vec%0d_ss", i), 32'(safe_stop), 32'(vecs[i].fc != 4'b0000));
      if (vecs[i].pv) chk($sformatf("vec%0d_speed", i), 32'(pair_speed), 32'(vecs[i].speed));
      if (vecs[i].fc != 4'b0000) exp_err++;
    end
    chk_err("vectors");
    clear_fault("post_vec");

    // Pair timeout: ch0 alone, fault after exactly C_PAIR cycles.
    drive(1'b1, mk(0, 10, 1), 1'b0, '0);
    repeat (C_PAIR - 1) step();
    chk("pair_to_before", 32'(fault_code), 32'd0);
    step();
    chk("pair_to_fc", 32'(fault_code), 32'b0100);
    chk("pair_to_ss", 32'(safe_stop), 32'd1);
    exp_err++;
    clear_fault("pair_to");

    // Repeat ch0 coinciding with ch1 while waiting for ch1.
    drive(1'b1, mk(0, 10, 1), 1'b0, '0);
    step(); step();
    drive(1'b1, mk(0, 10, 1), 1'b1, mk(0, 10, 1));
    chk("repeat_fc", 32'(fault_code), 32'b0010);
    chk("repeat_ss", 32'(safe_stop), 32'd1);
    exp_err++;
    clear_fault("repeat");

    // Split arrival: ch1 first, ch0 three cycles later.
    speed_margin = 25'd0;
    drive(1'b0, '0, 1'b1, mk(0, 50, 4));
    step(); step(); step();
    drive(1'b1, mk(0, 50, 4), 1'b0, '0);
    chk("split_early_pv", 32'(pair_valid), 32'd0);
    step();
    chk("split_pv", 32'(pair_valid), 32'd1);
    chk("split_speed", 32'(pair_speed), 32'd50);

    // Strobes during CHECK start the next frame.
    drive(1'b1, mk(0, 60, 5), 1'b1, mk(0, 60, 5));
    drive(1'b1, mk(0, 70, 6), 1'b0, '0);
    chk("ovl_pv1", 32'(pair_valid), 32'd1);
    chk("ovl_speed1", 32'(pair_speed), 32'd60);
    drive(1'b0, '0, 1'b1, mk(0, 70, 6));
    chk("ovl_gap_pv", 32'(pair_valid), 32'd0);
    step();
    chk("ovl_pv2", 32'(pair_valid), 32'd1);
    chk("ovl_speed2", 32'(pair_speed), 32'd70);
    chk("ovl_fc", 32'(fault_code), 32'd0);

    // Reset while waiting for ch0.
    drive(1'b0, '0, 1'b1, mk(0, 80, 7));
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_err = 0;
    chk("wrst_pv", 32'(pair_valid), 32'd0);
    chk("wrst_speed", 32'(pair_speed), 32'd0);
    chk("wrst_ss", 32'(safe_stop), 32'd0);
    chk("wrst_fc", 32'(fault_code), 32'd0);
    chk_err("wrst");
    drive(1'b1, mk(0, 1, 33), 1'b1, mk(0, 1, 33));
    step();
    chk("wrst_next_pv", 32'(pair_valid), 32'd1);
    chk("wrst_next_speed", 32'(pair_speed), 32'd1);

    // Frame timeout from reset, then two more faults for the statistics counter.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_err = 0;
    repeat (C_FRAME - 1) step();
    chk("frame_to_before", 32'(fault_code), 32'd0);
    step();
    chk("frame_to_fc", 32'(fault_code), 32'b0100);
    chk("frame_to_ss", 32'(safe_stop), 32'd1);
    exp_err++;
    chk_err("frame_to");
    clear_fault("frame_to");
    drive(1'b1, mk(0, 5, 1), 1'b0, '0);
    drive(1'b1, mk(0, 5, 1), 1'b0, '0);
    chk("stats_rep_fc", 32'(fault_code), 32'b0010);
    exp_err++;
    clear_fault("stats_rep");
    speed_margin = 25'd4;
    drive(1'b1, mk(0, 1000, 9), 1'b1, mk(0, 1010, 9));
    step();
    chk("stats_mm_fc", 32'(fault_code), 32'b0001);
    exp_err++;
    chk_err("stats_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
